// File: rtl/svlib_pkg.sv
// Shared types for the SVLib streaming blocks.
// The skid buffer state encoding doubles as its occupancy count.
package svlib_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_FULL  = 2'd1,
    SKID_SKID  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/register_en_sync_rst.sv
// Payload register with load enable and synchronous active-high reset.
// Reset takes priority over the load enable.
module register_en_sync_rst #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] data_q;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VAL;
    end else if (en) begin
      data_q <= din;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/skid_buffer_sync_rst.sv
// Two-entry valid/ready skid buffer: cuts valid/data and ready paths while
// sustaining one transfer per cycle. All outputs come straight from flops.
module skid_buffer_sync_rst
  import svlib_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic             s_ready_q;
  logic             m_valid_q;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_din;
  logic [WIDTH-1:0] skid_dout;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    skid_en  = 1'b0;
    main_din = s_data;
    case (state_q)
      SKID_EMPTY: begin
        if (s_valid) begin
          main_en = 1'b1;
          state_d = SKID_FULL;
        end
      end
      SKID_FULL: begin
        if (s_valid && m_ready) begin
          main_en = 1'b1;
        end else if (s_valid) begin
          skid_en = 1'b1;
          state_d = SKID_SKID;
        end else if (m_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_SKID: begin
        // s_ready is low here, so s_valid cannot carry a transfer.
        if (m_ready) begin
          main_din = skid_dout;
          main_en  = 1'b1;
          state_d  = SKID_FULL;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state rather than decoded
  // from state_q, keeping them free of any output logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SKID_EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != SKID_SKID);
      m_valid_q <= (state_d != SKID_EMPTY);
    end
  end

  register_en_sync_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .din (main_din),
    .dout(m_data)
  );

  register_en_sync_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .din (s_data),
    .dout(skid_dout)
  );

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_skid_buffer_sync_rst.sv
// Self-checking bench for skid_buffer_sync_rst: a FIFO-queue reference model
// fed at upstream handshakes and drained by a monitor at downstream handshakes.
module tb_skid_buffer_sync_rst;

  localparam int               WIDTH     = 8;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;
  localparam int               N_RANDOM  = 10000;
  localparam int               RAND_BUDGET = 60000;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occupancy;

  skid_buffer_sync_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a FIFO of at most two accepted items;
  // when empty, m_data shows the last item delivered (or RESET_VAL).
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] last_out;
  logic [WIDTH-1:0] exp_v;
  logic [WIDTH-1:0] hold_data;
  logic             hold_pending = 1'b0;
  logic             model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      check("occupancy", 32'(occupancy), sb_q.size());
      check("s_ready", 32'(s_ready), 32'(sb_q.size() < 2));
      check("m_valid", 32'(m_valid), 32'(sb_q.size() > 0));
      check("m_data", 32'(m_data), 32'((sb_q.size() > 0) ? sb_q[0] : last_out));
      if (hold_pending) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(hold_data));
      end
    end
    if (rst) begin
      sb_q.delete();
      last_out     = RESET_VAL;
      hold_pending = 1'b0;
      model_on     = 1'b1;
    end else if (model_on) begin
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_output: got 0x%0h, expected no output at %0t", m_data, $time);
        end else begin
          exp_v = sb_q.pop_front();
          check("order", 32'(m_data), 32'(exp_v));
          last_out = exp_v;
        end
        n_out++;
      end
      if (s_valid && s_ready) sb_q.push_back(s_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_out;
    int cyc;
    logic acc;

    // Reset with upstream asserting data that must be ignored.
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; m_ready = 1'b0;
    step();
    step();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'h00);
    check("rst_occ", 32'(occupancy), 32'd0);
    step();

    // Back-to-back streaming with the consumer always ready.
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i);
      @(negedge clk);
      check("stream_s_ready", 32'(s_ready), 32'd1);
      step();
    end
    s_valid = 1'b0;
    step();
    step();

    // Stall: two items fill main then skid while downstream is blocked.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    step();
    s_data = 8'h22;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("stall_occ", 32'(occupancy), 32'd2);
    check("stall_s_ready", 32'(s_ready), 32'd0);
    check("stall_m_data", 32'(m_data), 32'h11);
    step();
    m_ready = 1'b1;
    step();
    @(negedge clk);
    check("unstall_s_ready", 32'(s_ready), 32'd1);
    check("unstall_m_data", 32'(m_data), 32'h22);
    step();
    step();

    // Reset while holding two entries, with downstream ready on the reset edge.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    step();
    s_data = 8'h22;
    step();
    s_data = 8'h55; rst = 1'b1; m_ready = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b1; s_data = 8'h33;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("midrst_next_valid", 32'(m_valid), 32'd1);
    check("midrst_next_data", 32'(m_data), 32'h33);
    step();
    step();

    // Drain from FULL to EMPTY; main keeps the last delivered value.
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A;
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("drain_full_occ", 32'(occupancy), 32'd1);
    step();
    @(negedge clk);
    check("drain_m_valid", 32'(m_valid), 32'd0);
    check("drain_occ", 32'(occupancy), 32'd0);
    check("drain_m_data", 32'(m_data), 32'h5A);
    step();
    @(negedge clk);
    check("drain_retain", 32'(m_data), 32'h5A);
    step();

    // Random traffic; the producer holds data until it is accepted.
    start_out = n_out;
    cyc = 0;
    s_valid = 1'b0; m_ready = 1'b0;
    while ((n_out - start_out) < N_RANDOM && cyc < RAND_BUDGET) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      step();
      if (!s_valid || acc) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = WIDTH'($urandom);
      end
      m_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    if ((n_out - start_out) < N_RANDOM) begin
      n_cmp++;
      n_err++;
      $display("FAIL random_budget: got %0d transfers, expected %0d", n_out - start_out, N_RANDOM);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      step();
      if (acc) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    step();
    step();
    check("sb_empty_at_end", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
